dm_arbiter: RTL
===============

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter RR_INIT, default 0, meaning the master favoured first after reset (0 = m0, 1 = m1).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports m0_req/m1_req  input  1  request valid, held stable until granted.
REQ-005 SHALL have ports m0_we/m1_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have ports m0_be/m1_be  input  4  store byte enables, bit i = byte lane i.
REQ-007 SHALL have ports m0_addr/m1_addr  input  32  byte address; bits [1:0] are ignored.
REQ-008 SHALL have ports m0_wdata/m1_wdata  input  32  store data, lane-aligned.
REQ-009 SHALL have ports m0_gnt/m1_gnt  output  1  request accepted this cycle (combinational).
REQ-010 SHALL have ports m0_rvalid/m1_rvalid  output  1  registered load data valid.
REQ-011 SHALL have ports m0_rdata/m1_rdata  output  32  registered load data.
REQ-012 SHALL have port dm_we  output  1  write strobe to the word-wide data memory.
REQ-013 SHALL have port dm_addr  output  32  memory address, always {addr[31:2],2'b00}.
REQ-014 SHALL have port dm_wdata  output  32  memory write word.
REQ-015 SHALL have port dm_rdata  input  32  combinational memory read word at dm_addr.
REQ-016 SHALL have port busy  output  1  high while in state RMW.

Function
REQ-017 SHALL implement a two-state FSM: IDLE, RMW.
REQ-018 In IDLE with exactly one req high, SHALL grant that master in the same cycle.
REQ-019 In IDLE with both req high, SHALL grant the master indicated by round-robin pointer rr.
REQ-020 After any grant to master k, rr SHALL point to the other master on the next edge; rr SHALL be unchanged when no grant occurs.
REQ-021 Granted load: dm_we=0, dm_addr from winner; dm_rdata registered into winner's rdata, winner's rvalid high for exactly the following cycle; FSM stays IDLE.
REQ-022 Granted store with be=4'b1111: dm_we=1, dm_wdata=wdata in the grant cycle; FSM stays IDLE; no rvalid.
REQ-023 Granted store with be=4'b0000: no-op, dm_we=0, grant still asserted, FSM stays IDLE.
REQ-024 Granted store with partial be: grant cycle drives dm_we=0 and dm_addr; on the edge SHALL latch address and merged word (lane i = be[i] ? wdata lane : dm_rdata lane) and enter RMW.
REQ-025 In RMW: dm_we=1, dm_addr/dm_wdata from the latched values, both gnt low, busy high; next state IDLE unconditionally.
REQ-026 A request denied in one cycle SHALL remain eligible; a master held off by RMW SHALL be arbitrated in the following IDLE cycle.
REQ-027 Outside a grant or RMW cycle, dm_we SHALL be 0, and dm_addr/dm_wdata SHALL be 0.
REQ-028 rvalid SHALL be a one-cycle pulse; rdata SHALL hold its last value until the next load for that master.
REQ-029 A load following an RMW to the same word SHALL return the merged word.

Reset
REQ-030 While reset is high: dm_we=0, both gnt=0, busy=0, regardless of state or req.
REQ-031 On a reset edge: FSM=IDLE, rr=RR_INIT, both rvalid=0, both rdata=0, latched address/merge=0.
REQ-032 Reset asserted during RMW SHALL abandon the pending write; memory word unchanged.

Verification
REQ-033 m0 load addr 0x10 with dm_rdata=0xDEADBEEF -> m0_gnt same cycle, next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF.
REQ-034 Both req loads held for 4 cycles, RR_INIT=0 -> grants m0,m1,m0,m1.
REQ-035 m1 store be=4'b0010, wdata=0x0000AB00 to a word holding 0x11223344 -> grant, then RMW cycle dm_we=1, dm_wdata=0x1122AB44, busy=1.
REQ-036 m0 partial store while m1 req high -> m1_gnt low during RMW, m1 granted first IDLE cycle after.
REQ-037 reset high in RMW cycle -> dm_we=0, next cycle IDLE, rr=RR_INIT, rvalid=0, target word unchanged.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter in front of a word-wide data memory.
// Partial-lane stores are completed as a read-modify-write in one extra cycle.
module dm_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic        busy
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RMW = 1'b1} state_t;

  state_t      state_r;
  logic        rr_r;
  logic        m0_rvalid_r;
  logic        m1_rvalid_r;
  logic [31:0] m0_rdata_r;
  logic [31:0] m1_rdata_r;
  logic [31:0] lat_addr_r;
  logic [31:0] lat_data_r;

  logic        sel_m1_s;
  logic        grant_s;
  logic        w_we_s;
  logic [3:0]  w_be_s;
  logic [31:0] w_addr_s;
  logic [31:0] w_wdata_s;
  logic        full_s;
  logic        partial_s;

  function automatic logic [31:0] merge_lanes(input logic [3:0] be,
                                              input logic [31:0] wdata,
                                              input logic [31:0] rdata);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = be[i] ? wdata[i*8 +: 8] : rdata[i*8 +: 8];
    end
    return res;
  endfunction

  // Winner selection: a lone requester wins, ties go to the master rr points at.
  always_comb begin
    sel_m1_s  = m1_req & (~m0_req | rr_r);
    grant_s   = (state_r == ST_IDLE) & ~reset & (m0_req | m1_req);
    if (sel_m1_s) begin
      w_we_s    = m1_we;
      w_be_s    = m1_be;
      w_addr_s  = m1_addr;
      w_wdata_s = m1_wdata;
    end else begin
      w_we_s    = m0_we;
      w_be_s    = m0_be;
      w_addr_s  = m0_addr;
      w_wdata_s = m0_wdata;
    end
    full_s    = (w_be_s == 4'b1111);
    partial_s = (w_be_s != 4'b0000) & ~full_s;
  end

  // Grant and memory-side drive; everything idles to zero outside grant/RMW.
  always_comb begin
    m0_gnt   = grant_s & ~sel_m1_s;
    m1_gnt   = grant_s & sel_m1_s;
    busy     = (state_r == ST_RMW) & ~reset;
    dm_we    = 1'b0;
    dm_addr  = 32'h0000_0000;
    dm_wdata = 32'h0000_0000;
    if (reset) begin
      dm_we = 1'b0;
    end else if (state_r == ST_RMW) begin
      dm_we    = 1'b1;
      dm_addr  = lat_addr_r;
      dm_wdata = lat_data_r;
    end else if (grant_s) begin
      dm_addr = {w_addr_s[31:2], 2'b00};
      if (w_we_s && full_s) begin
        dm_we    = 1'b1;
        dm_wdata = w_wdata_s;
      end else begin
        dm_we = 1'b0;
      end
    end else begin
      dm_we = 1'b0;
    end
  end

  // FSM, round-robin pointer, load return registers and RMW latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rr_r        <= RR_INIT;
      m0_rvalid_r <= 1'b0;
      m1_rvalid_r <= 1'b0;
      m0_rdata_r  <= 32'h0000_0000;
      m1_rdata_r  <= 32'h0000_0000;
      lat_addr_r  <= 32'h0000_0000;
      lat_data_r  <= 32'h0000_0000;
    end else begin
      m0_rvalid_r <= 1'b0;
      m1_rvalid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            rr_r <= ~sel_m1_s;
            if (!w_we_s) begin
              if (sel_m1_s) begin
                m1_rvalid_r <= 1'b1;
                m1_rdata_r  <= dm_rdata;
              end else begin
                m0_rvalid_r <= 1'b1;
                m0_rdata_r  <= dm_rdata;
              end
            end else if (partial_s) begin
              lat_addr_r <= {w_addr_s[31:2], 2'b00};
              lat_data_r <= merge_lanes(w_be_s, w_wdata_s, dm_rdata);
              state_r    <= ST_RMW;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RMW: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_rvalid = m0_rvalid_r;
  assign m1_rvalid = m1_rvalid_r;
  assign m0_rdata  = m0_rdata_r;
  assign m1_rdata  = m1_rdata_r;

endmodule
